// File: rtl/sr_latch_pulse_sched_pkg.sv
// Shared types and sizing helpers for the SR latch pulse scheduler.
// The FSM state enum is also used for the debug state output.
package sr_sched_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_PULSE,
    ST_GAP
  } state_e;

  localparam logic OP_SET   = 1'b1;
  localparam logic OP_RESET = 1'b0;

  // Counter must hold the larger of the two reload values (width - 1).
  function automatic int cnt_width(input int pulse_w, input int gap_w);
    int m;
    m = (pulse_w > gap_w) ? pulse_w : gap_w;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sr_latch_pulse_sched_rr_arbiter.sv
// Round-robin arbiter: searches ptr+1 .. ptr+N (mod N) and grants the first
// valid requester, returning both a one-hot grant and its binary index.
module rr_arbiter
  import sr_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sr_latch_pulse_sched.sv
// Sequences one shared NOR SR latch for N_REQ requesters: round-robin pick,
// fixed-width s/r pulse, then a mandatory idle gap. Never drives S=R=1.
module sr_latch_pulse_sched
  import sr_sched_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int PULSE_W    = 2,
  parameter int GAP_W      = 1,
  parameter int INIT_CLEAR = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_op,
  output logic [N_REQ-1:0] req_ready,
  output logic             s_out,
  output logic             r_out,
  output logic             busy,
  output logic             q_exp,
  output logic             q_known,
  output state_e           dbg_state
);

  localparam int CW = cnt_width(PULSE_W, GAP_W);
  localparam int IW = idx_width(N_REQ);
  localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_W - 1);
  localparam logic [CW-1:0] GAP_LD    = (GAP_W > 0) ? CW'(GAP_W - 1) : '0;
  localparam state_e        RST_STATE = (INIT_CLEAR != 0) ? ST_INIT : ST_IDLE;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            op_q, op_d;
  logic            s_q, s_d;
  logic            r_q, r_d;
  logic            qe_q, qe_d;
  logic            qk_q, qk_d;

  logic [N_REQ-1:0] gnt;
  logic [IW-1:0]    win_idx;
  logic             win_any;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (win_any)
  );

  // Handshake: a transfer happens on req_valid[i] & req_ready[i]. req_ready is
  // combinational, only in IDLE, and one-hot to the arbiter winner; requesters
  // hold valid/op until accepted and may withdraw before that.
  assign req_ready = (state_q == ST_IDLE) ? gnt : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    s_d     = s_q;
    r_d     = r_q;
    qe_d    = qe_q;
    qk_d    = qk_q;
    case (state_q)
      ST_INIT: begin
        state_d = ST_PULSE;
        cnt_d   = PULSE_LD;
        op_d    = OP_RESET;
        s_d     = 1'b0;
        r_d     = 1'b1;
      end
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_PULSE;
          cnt_d   = PULSE_LD;
          op_d    = req_op[win_idx];
          ptr_d   = win_idx;
          s_d     = req_op[win_idx];
          r_d     = ~req_op[win_idx];
        end
      end
      ST_PULSE: begin
        if (cnt_q == '0) begin
          // Pulse complete: the latch now holds op, so the model becomes valid.
          s_d  = 1'b0;
          r_d  = 1'b0;
          qe_d = op_q;
          qk_d = 1'b1;
          if (GAP_W == 0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        s_d     = 1'b0;
        r_d     = 1'b0;
      end
    endcase
  end

  // Reset drops the drive immediately and forgets the latch state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      op_q    <= OP_RESET;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      qe_q    <= 1'b0;
      qk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      s_q     <= s_d;
      r_q     <= r_d;
      qe_q    <= qe_d;
      qk_q    <= qk_d;
    end
  end

  assign s_out     = s_q;
  assign r_out     = r_q;
  assign q_exp     = qe_q;
  assign q_known   = qk_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
